// File: rtl/i2c_bridge_pkg.sv
// rtl/i2c_bridge_pkg.sv - shared types and constants for the AXI-to-I2C bridge
//
// Purpose: FSM state encoding, AXI response codes, command-word layout and
// the helper that packs a command word from its fields.
package i2c_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_RD_DATA,
    ST_WR_RESP,
    ST_RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Command word layout: {rnw, slave_addr[6:0], reg[7:0], wdata[7:0]}
  localparam int CMD_WDATA_LSB = 0;
  localparam int CMD_REG_LSB   = 8;
  localparam int CMD_SADDR_LSB = 16;
  localparam int CMD_RNW_BIT   = 23;

  // Where the I2C fields sit inside an AXI byte address
  localparam int AXI_REG_LSB   = 2;
  localparam int AXI_SADDR_LSB = 10;

  typedef struct packed {
    logic       rnw;
    logic [6:0] slave_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
  } i2c_cmd_t;

  localparam int CMD_W = $bits(i2c_cmd_t);

  function automatic i2c_cmd_t pack_cmd(input logic       rnw,
                                        input logic [6:0] saddr,
                                        input logic [7:0] raddr,
                                        input logic [7:0] wdata);
    logic [CMD_W-1:0] w;
    w                       = '0;
    w[CMD_RNW_BIT]          = rnw;
    w[CMD_SADDR_LSB +: 7]   = saddr;
    w[CMD_REG_LSB +: 8]     = raddr;
    w[CMD_WDATA_LSB +: 8]   = wdata;
    return i2c_cmd_t'(w);
  endfunction

endpackage

// File: rtl/axi_to_i2c_timeout.sv
// rtl/axi_to_i2c_timeout.sv - saturating response timeout counter
//
// Purpose: counts cycles while count_en_i is high, restarts from zero on
// restart_i, and flags expiry on the TIMEOUT_CYCLES-th counted cycle.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   restart_i   clear the count (takes priority over counting)
//   count_en_i  count this cycle
//   expired_o   high during the TIMEOUT_CYCLES-th enabled cycle and after
module axi_to_i2c_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of enabled cycles already completed, so the
  // current cycle is cycle cnt_q+1; it parks at LAST instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = count_en_i & (cnt_q == LAST);

endmodule

// File: rtl/axi_lite_i2c_cmd_slave.sv
// rtl/axi_lite_i2c_cmd_slave.sv - AXI4-Lite slave that turns accesses into I2C command words
//
// Purpose: captures one AXI4-Lite write (AW+W) or read (AR) at a time,
// issues a packed I2C command word downstream, waits for ACK/NACK (and the
// read byte), and answers on B or R. Unanswered commands time out to SLVERR.
// Ports:
//   ACLK, ARESET                       clock, synchronous active-high reset
//   AW*/W*/B*                          AXI4-Lite write channels
//   AR*/R*                             AXI4-Lite read channels
//   ADDR_DATA_OUT, VALID_ADDR_DATA_OUT command word and its valid
//   VALID_ADDR_DATA_OUT_ACK_VALID/_ACK downstream ACK status
//   RDATA_OUT, RDATA_VALID             downstream read byte
//   RDATA_VALID_ACK                    one-cycle consume pulse for the read byte
//   PENDING_TRANSACTION_WR/_RD         downstream busy; blocks new issues
module axi_lite_i2c_cmd_slave
  import i2c_bridge_pkg::*;
#(
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          CMD_WIDTH      = 24,
  parameter int          RDATA_WIDTH    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RVALID,
  input  logic                        RREADY,
  output logic [CMD_WIDTH-1:0]        ADDR_DATA_OUT,
  output logic                        VALID_ADDR_DATA_OUT,
  input  logic                        VALID_ADDR_DATA_OUT_ACK_VALID,
  input  logic                        VALID_ADDR_DATA_OUT_ACK,
  input  logic [RDATA_WIDTH-1:0]      RDATA_OUT,
  input  logic                        RDATA_VALID,
  output logic                        RDATA_VALID_ACK,
  input  logic                        PENDING_TRANSACTION_WR,
  input  logic                        PENDING_TRANSACTION_RD
);

  state_t                      state_q, state_d;
  logic                        aw_full_q, aw_full_d;
  logic [6:0]                  aw_saddr_q, aw_saddr_d;
  logic [7:0]                  aw_reg_q, aw_reg_d;
  logic                        w_full_q, w_full_d;
  logic [7:0]                  w_data_q, w_data_d;
  logic                        w_strb0_q, w_strb0_d;
  i2c_cmd_t                    cmd_q, cmd_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic [1:0]                  rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                        last_wr_q, last_wr_d;

  logic idle, pend_any, wr_cand, wr_sel;
  logic aw_hs, w_hs, ar_hs;
  logic tmo_restart, tmo_count_en, tmo_expired;
  logic unused_inputs;

  assign idle     = (state_q == ST_IDLE);
  assign pend_any = PENDING_TRANSACTION_WR | PENDING_TRANSACTION_RD;
  assign wr_cand  = aw_full_q & w_full_q;

  // On a tie with a pending read, the write goes only if the read was the
  // one served last.
  assign wr_sel = idle & ~pend_any & wr_cand & (~ARVALID | ~last_wr_q);

  // Readies are forced low during reset so same-cycle requests are dropped.
  assign AWREADY = ~ARESET & idle & ~aw_full_q;
  assign WREADY  = ~ARESET & idle & ~w_full_q;
  assign ARREADY = ~ARESET & idle & ~pend_any & ~wr_sel;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  assign tmo_count_en = (state_q == ST_WR_ISSUE) || (state_q == ST_RD_ISSUE) ||
                        (state_q == ST_RD_DATA);
  assign tmo_restart  = (state_d != state_q);

  axi_to_i2c_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .restart_i  (tmo_restart),
    .count_en_i (tmo_count_en),
    .expired_o  (tmo_expired)
  );

  always_comb begin
    state_d             = state_q;
    aw_full_d           = aw_full_q;
    aw_saddr_d          = aw_saddr_q;
    aw_reg_d            = aw_reg_q;
    w_full_d            = w_full_q;
    w_data_d            = w_data_q;
    w_strb0_d           = w_strb0_q;
    cmd_d               = cmd_q;
    bresp_d             = bresp_q;
    rresp_d             = rresp_q;
    rdata_d             = rdata_q;
    last_wr_d           = last_wr_q;
    VALID_ADDR_DATA_OUT = 1'b0;
    RDATA_VALID_ACK     = 1'b0;

    if (aw_hs) begin
      aw_full_d  = 1'b1;
      aw_saddr_d = AWADDR[AXI_SADDR_LSB +: 7];
      aw_reg_d   = AWADDR[AXI_REG_LSB +: 8];
    end
    if (w_hs) begin
      w_full_d  = 1'b1;
      w_data_d  = WDATA[7:0];
      w_strb0_d = WSTRB[0];
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_sel) begin
          last_wr_d = 1'b1;
          cmd_d     = pack_cmd(1'b0, aw_saddr_q, aw_reg_q, w_data_q);
          if (w_strb0_q) begin
            state_d = ST_WR_ISSUE;
          end else begin
            // Low byte not written: nothing to send, refuse immediately.
            bresp_d = RESP_SLVERR;
            state_d = ST_WR_RESP;
          end
        end else if (ar_hs) begin
          last_wr_d = 1'b0;
          cmd_d     = pack_cmd(1'b1, ARADDR[AXI_SADDR_LSB +: 7],
                               ARADDR[AXI_REG_LSB +: 8], 8'h00);
          state_d   = ST_RD_ISSUE;
        end
      end

      ST_WR_ISSUE: begin
        VALID_ADDR_DATA_OUT = 1'b1;
        if (VALID_ADDR_DATA_OUT_ACK_VALID) begin
          bresp_d = VALID_ADDR_DATA_OUT_ACK ? RESP_OKAY : RESP_SLVERR;
          state_d = ST_WR_RESP;
        end else if (tmo_expired) begin
          bresp_d = RESP_SLVERR;
          state_d = ST_WR_RESP;
        end
      end

      ST_RD_ISSUE: begin
        VALID_ADDR_DATA_OUT = 1'b1;
        if (VALID_ADDR_DATA_OUT_ACK_VALID && VALID_ADDR_DATA_OUT_ACK) begin
          state_d = ST_RD_DATA;
        end else if (VALID_ADDR_DATA_OUT_ACK_VALID || tmo_expired) begin
          rresp_d = RESP_SLVERR;
          rdata_d = '0;
          state_d = ST_RD_RESP;
        end
      end

      ST_RD_DATA: begin
        if (RDATA_VALID) begin
          RDATA_VALID_ACK = 1'b1;
          rresp_d         = RESP_OKAY;
          rdata_d         = {{(AXI_DATA_WIDTH-RDATA_WIDTH){1'b0}}, RDATA_OUT};
          state_d         = ST_RD_RESP;
        end else if (tmo_expired) begin
          rresp_d = RESP_SLVERR;
          rdata_d = '0;
          state_d = ST_RD_RESP;
        end
      end

      ST_WR_RESP: begin
        if (BREADY) begin
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      ST_RD_RESP: begin
        if (RREADY) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      aw_full_q  <= 1'b0;
      aw_saddr_q <= '0;
      aw_reg_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb0_q  <= 1'b0;
      cmd_q      <= '0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      last_wr_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      aw_full_q  <= aw_full_d;
      aw_saddr_q <= aw_saddr_d;
      aw_reg_q   <= aw_reg_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb0_q  <= w_strb0_d;
      cmd_q      <= cmd_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      last_wr_q  <= last_wr_d;
    end
  end

  assign ADDR_DATA_OUT = cmd_q;
  assign BVALID        = (state_q == ST_WR_RESP);
  assign BRESP         = bresp_q;
  assign RVALID        = (state_q == ST_RD_RESP);
  assign RRESP         = rresp_q;
  assign RDATA         = rdata_q;

  // Address bits outside the I2C fields, data above the low byte and the
  // upper strobes carry no meaning for an 8-bit I2C register access.
  assign unused_inputs = ^{AWADDR[AXI_ADDR_WIDTH-1:17], AWADDR[1:0],
                           ARADDR[AXI_ADDR_WIDTH-1:17], ARADDR[1:0],
                           WDATA[AXI_DATA_WIDTH-1:8], WSTRB[AXI_DATA_WIDTH/8-1:1]};

endmodule

// File: tb/tb_axi_lite_i2c_cmd_slave.sv
// tb/tb_axi_lite_i2c_cmd_slave.sv - self-checking bench for axi_lite_i2c_cmd_slave
module tb_axi_lite_i2c_cmd_slave;

  localparam int TMO = 16;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [23:0] ADDR_DATA_OUT;
  logic        VALID_ADDR_DATA_OUT;
  logic        VALID_ADDR_DATA_OUT_ACK_VALID;
  logic        VALID_ADDR_DATA_OUT_ACK;
  logic [7:0]  RDATA_OUT;
  logic        RDATA_VALID;
  logic        RDATA_VALID_ACK;
  logic        PENDING_TRANSACTION_WR;
  logic        PENDING_TRANSACTION_RD;

  always #5 ACLK = ~ACLK;

  axi_lite_i2c_cmd_slave #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .ACLK                          (ACLK),
    .ARESET                        (ARESET),
    .AWADDR                        (AWADDR),
    .AWVALID                       (AWVALID),
    .AWREADY                       (AWREADY),
    .WDATA                         (WDATA),
    .WSTRB                         (WSTRB),
    .WVALID                        (WVALID),
    .WREADY                        (WREADY),
    .BRESP                         (BRESP),
    .BVALID                        (BVALID),
    .BREADY                        (BREADY),
    .ARADDR                        (ARADDR),
    .ARVALID                       (ARVALID),
    .ARREADY                       (ARREADY),
    .RDATA                         (RDATA),
    .RRESP                         (RRESP),
    .RVALID                        (RVALID),
    .RREADY                        (RREADY),
    .ADDR_DATA_OUT                 (ADDR_DATA_OUT),
    .VALID_ADDR_DATA_OUT           (VALID_ADDR_DATA_OUT),
    .VALID_ADDR_DATA_OUT_ACK_VALID (VALID_ADDR_DATA_OUT_ACK_VALID),
    .VALID_ADDR_DATA_OUT_ACK       (VALID_ADDR_DATA_OUT_ACK),
    .RDATA_OUT                     (RDATA_OUT),
    .RDATA_VALID                   (RDATA_VALID),
    .RDATA_VALID_ACK               (RDATA_VALID_ACK),
    .PENDING_TRANSACTION_WR        (PENDING_TRANSACTION_WR),
    .PENDING_TRANSACTION_RD        (PENDING_TRANSACTION_RD)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          ar_seen;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Reference model: fields pulled out of the byte address arithmetically.
  function automatic logic [23:0] model_word(input bit rnw, input logic [31:0] addr,
                                             input logic [7:0] d);
    int unsigned a, sa, ra, w;
    a  = addr;
    sa = (a / 1024) % 128;
    ra = (a / 4) % 256;
    w  = (rnw ? 8388608 : 0) + sa * 65536 + ra * 256 + d;
    return w[23:0];
  endfunction

  function automatic logic [1:0] model_bresp(input bit strb0, input bit tmo, input bit ack);
    return (strb0 && !tmo && ack) ? 2'b00 : 2'b10;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {VALID_ADDR_DATA_OUT, BVALID, RVALID, RDATA_VALID_ACK,
                          AWREADY, WREADY, ARREADY}, 0);
    check({tag, "_resp"}, {BRESP, RRESP}, 0);
    check({tag, "_cmd"}, ADDR_DATA_OUT, 0);
    check({tag, "_rdata"}, RDATA, 0);
  endtask

  task automatic reset_dut();
    ARESET = 1'b1;
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
    VALID_ADDR_DATA_OUT_ACK_VALID = 0; VALID_ADDR_DATA_OUT_ACK = 0;
    RDATA_VALID = 0; RDATA_OUT = 0;
    PENDING_TRANSACTION_WR = 0; PENDING_TRANSACTION_RD = 0;
    tick();
    tick();
    ARESET = 1'b0;
    tick();
  endtask

  // Called on the first sample where the command should be valid.
  task automatic run_issue(input string tag, input logic [23:0] word, input bit tmo,
                           input int delay, input bit ack);
    int hi;
    check({tag, "_valid"}, VALID_ADDR_DATA_OUT, 1);
    check({tag, "_word"}, ADDR_DATA_OUT, word);
    if (tmo) begin
      hi = 0;
      while (VALID_ADDR_DATA_OUT === 1'b1 && hi < TMO + 8) begin
        hi++;
        tick();
      end
      check({tag, "_tmo_len"}, hi, TMO);
    end else begin
      for (int i = 0; i < delay; i++) tick();
      check({tag, "_hold"}, {VALID_ADDR_DATA_OUT, ADDR_DATA_OUT}, {1'b1, word});
      VALID_ADDR_DATA_OUT_ACK_VALID = 1'b1;
      VALID_ADDR_DATA_OUT_ACK       = ack;
      tick();
      VALID_ADDR_DATA_OUT_ACK_VALID = 1'b0;
      VALID_ADDR_DATA_OUT_ACK       = 1'($urandom);
      check({tag, "_drop"}, VALID_ADDR_DATA_OUT, 0);
    end
  endtask

  task automatic run_resp_b(input string tag, input logic [1:0] exp_resp);
    int d;
    check({tag, "_bvalid"}, BVALID, 1);
    check({tag, "_bresp"}, BRESP, exp_resp);
    d = $urandom_range(0, 3);
    for (int i = 0; i < d; i++) begin
      VALID_ADDR_DATA_OUT_ACK_VALID = 1'($urandom);
      RDATA_VALID = 1'($urandom);
      #1;
      check({tag, "_noise_rack"}, RDATA_VALID_ACK, 0);
      tick();
    end
    VALID_ADDR_DATA_OUT_ACK_VALID = 0;
    RDATA_VALID = 0;
    BREADY = 1;
    check({tag, "_bstable"}, {BVALID, BRESP}, {1'b1, exp_resp});
    tick();
    BREADY = 0;
    check({tag, "_bdone"}, BVALID, 0);
  endtask

  task automatic run_resp_r(input string tag, input logic [1:0] exp_resp, input logic [31:0] exp_data);
    int d;
    check({tag, "_rvalid"}, RVALID, 1);
    check({tag, "_rresp"}, RRESP, exp_resp);
    check({tag, "_rdata"}, RDATA, exp_data);
    d = $urandom_range(0, 3);
    for (int i = 0; i < d; i++) begin
      VALID_ADDR_DATA_OUT_ACK_VALID = 1'($urandom);
      RDATA_VALID = 1'($urandom);
      #1;
      check({tag, "_noise_rack"}, RDATA_VALID_ACK, 0);
      tick();
    end
    VALID_ADDR_DATA_OUT_ACK_VALID = 0;
    RDATA_VALID = 0;
    RREADY = 1;
    check({tag, "_rstable"}, {RVALID, RRESP, RDATA}, {1'b1, exp_resp, exp_data});
    tick();
    RREADY = 0;
    check({tag, "_rdone"}, RVALID, 0);
  endtask

  // Called on the first sample after an ACKed read command.
  task automatic read_data_phase(input string tag, input bit tmo, input int ddelay,
                                 input logic [7:0] rbyte);
    int hi;
    check({tag, "_wait_data"}, RVALID, 0);
    if (tmo) begin
      hi = 0;
      while (RVALID !== 1'b1 && hi < TMO + 8) begin
        hi++;
        tick();
      end
      check({tag, "_dtmo_len"}, hi, TMO);
    end else begin
      for (int i = 0; i < ddelay; i++) tick();
      RDATA_OUT   = rbyte;
      RDATA_VALID = 1'b1;
      #1;
      check({tag, "_rack"}, RDATA_VALID_ACK, 1);
      tick();
      RDATA_VALID = 1'b0;
      RDATA_OUT   = 8'($urandom);
      #1;
      check({tag, "_rack_once"}, RDATA_VALID_ACK, 0);
    end
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit ack, input int delay,
                          input bit tmo, input bit w_lag);
    logic [23:0] word;
    word = model_word(1'b0, addr, data[7:0]);
    AWADDR = addr; AWVALID = 1;
    WDATA = data; WSTRB = strb; WVALID = !w_lag;
    #1;
    check({tag, "_awready"}, AWREADY, 1);
    tick();
    AWVALID = 0; AWADDR = $urandom;
    if (w_lag) begin
      WVALID = 1;
      #1;
      check({tag, "_wready"}, WREADY, 1);
      tick();
    end
    WVALID = 0; WDATA = $urandom;
    check({tag, "_not_yet"}, VALID_ADDR_DATA_OUT, 0);
    tick();
    if (strb[0]) begin
      run_issue(tag, word, tmo, delay, ack);
    end else begin
      check({tag, "_skip"}, VALID_ADDR_DATA_OUT, 0);
    end
    run_resp_b(tag, model_bresp(strb[0], tmo, ack));
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input bit ack,
                         input int delay, input bit tmo_issue, input logic [7:0] rbyte,
                         input int ddelay, input bit tmo_data);
    bit good;
    ARADDR = addr; ARVALID = 1;
    #1;
    check({tag, "_arready"}, ARREADY, 1);
    tick();
    ARVALID = 0; ARADDR = $urandom;
    run_issue(tag, model_word(1'b1, addr, 8'h00), tmo_issue, delay, ack);
    if (!tmo_issue && ack) read_data_phase(tag, tmo_data, ddelay, rbyte);
    good = !tmo_issue && ack && !tmo_data;
    run_resp_r(tag, good ? 2'b00 : 2'b10, good ? {24'h0, rbyte} : 32'h0);
  endtask

  task automatic wait_cmd(input string tag);
    int g;
    g = 0;
    while (VALID_ADDR_DATA_OUT !== 1'b1 && g < 20) begin
      if (ARVALID && ARREADY) ar_seen = 1;
      tick();
      if (ar_seen) ARVALID = 0;
      g++;
    end
    check({tag, "_cmd_seen"}, g < 20, 1);
  endtask

  initial begin
    logic [31:0] a, d, wa, wd, ra;
    logic [3:0]  s;
    bit          busy, any_resp;
    int          sel;

    AWADDR = 0; WDATA = 0; WSTRB = 0; ARADDR = 0;
    reset_dut();

    // reset state: check while reset is held
    ARESET = 1;
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    tick();
    check_all_zero("reset");
    ARESET = 0; AWVALID = 0; WVALID = 0; ARVALID = 0;
    tick();

    // directed cases
    do_write("wr_ack", 32'h0001_2008, 32'h0000_00A5, 4'hF, 1, 2, 0, 0);
    do_read("rd_ack", 32'h0000_A00C, 1, 0, 0, 8'h3C, 1, 0);
    do_write("wr_nack", 32'h00FF_FFFF, 32'h1234_5678, 4'h1, 0, 0, 0, 1);
    do_read("rd_nack", 32'h0001_0400, 0, 3, 0, 8'h55, 0, 0);
    do_write("wr_strb", 32'h0000_3004, 32'h0000_0011, 4'hE, 1, 0, 0, 0);
    do_write("wr_tmo", 32'h0000_8888, 32'h0000_00F0, 4'hF, 1, 0, 1, 0);
    do_read("rd_tmo", 32'h0000_7FFC, 1, 0, 1, 8'h00, 0, 0);
    do_read("rd_dtmo", 32'h0001_FFFC, 1, 1, 0, 8'h99, 0, 1);

    // simultaneous write and read after reset, held back by a busy flag
    reset_dut();
    PENDING_TRANSACTION_WR = 1;
    wa = 32'h0000_5C10; wd = 32'h0000_0077; ra = 32'h0001_F3FC;
    exp_q.delete();
    exp_q.push_back(model_word(1'b1, ra, 8'h00));
    exp_q.push_back(model_word(1'b0, wa, wd[7:0]));
    AWADDR = wa; AWVALID = 1; WDATA = wd; WSTRB = 4'hF; WVALID = 1;
    ARADDR = ra; ARVALID = 1;
    #1;
    check("arb_awready", AWREADY & WREADY, 1);
    ar_seen = 0;
    if (ARVALID && ARREADY) ar_seen = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    if (ar_seen) ARVALID = 0;
    busy = 0;
    for (int i = 0; i < 5; i++) begin
      busy |= VALID_ADDR_DATA_OUT;
      if (ARVALID && ARREADY) ar_seen = 1;
      tick();
      if (ar_seen) ARVALID = 0;
    end
    check("arb_pending_hold", busy, 0);
    PENDING_TRANSACTION_WR = 0;
    wait_cmd("arb_first");
    run_issue("arb_first", exp_q.pop_front(), 0, 1, 1);
    read_data_phase("arb_first", 0, 0, 8'hC3);
    run_resp_r("arb_first", 2'b00, 32'h0000_00C3);
    ARVALID = 0;
    wait_cmd("arb_second");
    run_issue("arb_second", exp_q.pop_front(), 0, 0, 1);
    run_resp_b("arb_second", 2'b00);

    // reset in the middle of an issue: silent abort
    AWADDR = 32'h0000_4444; AWVALID = 1; WDATA = 32'h0000_0042; WSTRB = 4'hF; WVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    tick();
    check("rst_mid_issue", VALID_ADDR_DATA_OUT, 1);
    tick(); tick();
    ARESET = 1;
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    tick();
    check_all_zero("rst_mid");
    ARESET = 0; AWVALID = 0; WVALID = 0; ARVALID = 0;
    any_resp = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_resp |= BVALID | RVALID | VALID_ADDR_DATA_OUT;
    end
    check("rst_no_resp", any_resp, 0);
    check("rst_ready_back", {AWREADY, WREADY, ARREADY}, 3'b111);

    // randomized traffic against the model
    for (int n = 0; n < 24; n++) begin
      a   = $urandom;
      d   = $urandom;
      sel = $urandom_range(0, 7);
      if (n % 2 == 0 || sel == 0) begin
        s = 4'($urandom);
        if (sel == 1) s[0] = 1'b0; else s[0] = 1'b1;
        do_write($sformatf("rnd_wr%0d", n), a, d, s, 1'($urandom), $urandom_range(0, TMO - 3),
                 sel == 2, 1'($urandom));
      end else begin
        do_read($sformatf("rnd_rd%0d", n), a, sel != 3, $urandom_range(0, TMO - 3), sel == 4,
                d[7:0], $urandom_range(0, TMO - 3), sel == 5);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
